// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing one main-memory line-refill port between cache requesters.
// One refill in flight; the returned line is handed back with a one-cycle ready pulse.
module refill_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [LINE_BITS-1:0]       req_data_o,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [LINE_BITS-1:0]       mem_data_in_i,
  input  logic                       mem_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned OffW = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                 state_q, state_d;
  logic [IdW-1:0]         grant_q, grant_d;
  logic [IdW-1:0]         last_q, last_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic [LINE_BITS-1:0]   req_data_q, req_data_d;
  logic                   busy_q, busy_d;

  logic                   pick_found;
  logic [IdW-1:0]         pick_id;
  logic [IdW-1:0]         cand;
  logic [ADDR_W-1:0]      line_addr;

  // Scan from last_q+1 upward, wrapping, so the pointer alone breaks ties.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_q) + k) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
    line_addr            = req_addr_i[32'(pick_id) * ADDR_W +: ADDR_W];
    line_addr[OffW-1:0]  = '0;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    req_ready_d = '0;
    req_data_d  = req_data_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = pick_id;
          mem_addr_d = line_addr;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (mem_ready_i) begin
          req_data_d           = mem_data_in_i;
          mem_req_d            = 1'b0;
          req_ready_d[grant_q] = 1'b1;
          state_d              = StResp;
        end
      end
      StResp: begin
        last_d  = grant_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= IdW'(NUM_REQ - 1);
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      req_ready_q <= '0;
      req_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      req_ready_q <= req_ready_d;
      req_data_q  <= req_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign req_data_o  = req_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed self-checking bench for refill_arbiter: a 2-requester and a 4-requester instance.
module tb_refill_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NUM_REQ = 2
  logic [1:0]   a_valid;
  logic [63:0]  a_addr;
  logic [1:0]   a_ready;
  logic [127:0] a_data;
  logic         a_mem_req;
  logic [31:0]  a_mem_addr;
  logic [127:0] a_mem_data;
  logic         a_mem_ready;
  logic [0:0]   a_grant;
  logic         a_busy;

  // Instance B: NUM_REQ = 4
  logic [3:0]   b_valid;
  logic [127:0] b_addr;
  logic [3:0]   b_ready;
  logic [127:0] b_data;
  logic         b_mem_req;
  logic [31:0]  b_mem_addr;
  logic [127:0] b_mem_data;
  logic         b_mem_ready;
  logic [1:0]   b_grant;
  logic         b_busy;

  refill_arbiter #(.NUM_REQ(2), .ADDR_W(32), .LINE_BITS(128)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (a_valid),
    .req_addr_i    (a_addr),
    .req_ready_o   (a_ready),
    .req_data_o    (a_data),
    .mem_req_o     (a_mem_req),
    .mem_addr_o    (a_mem_addr),
    .mem_data_in_i (a_mem_data),
    .mem_ready_i   (a_mem_ready),
    .grant_id_o    (a_grant),
    .busy_o        (a_busy)
  );

  refill_arbiter #(.NUM_REQ(4), .ADDR_W(32), .LINE_BITS(128)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (b_valid),
    .req_addr_i    (b_addr),
    .req_ready_o   (b_ready),
    .req_data_o    (b_data),
    .mem_req_o     (b_mem_req),
    .mem_addr_o    (b_mem_addr),
    .mem_data_in_i (b_mem_data),
    .mem_ready_i   (b_mem_ready),
    .grant_id_o    (b_grant),
    .busy_o        (b_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_req();
    for (int i = 0; i < 10 && !a_mem_req; i++) tick();
  endtask

  logic [127:0] line_a5;
  logic [127:0] line_d0;
  logic [127:0] line_d1;

  initial begin
    line_a5 = {16{8'hA5}};
    line_d0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    line_d1 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
    rst = 1'b0;
    a_valid = '0; a_addr = '0; a_mem_data = '0; a_mem_ready = 1'b0;
    b_valid = '0; b_addr = '0; b_mem_data = '0; b_mem_ready = 1'b0;
    #12;
    check("rst_mem_req", a_mem_req, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_ready", a_ready, 0);
    check("rst_data", a_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_grant", a_grant, 0);
    rst = 1'b1;

    // Single request
    a_valid = 2'b01;
    a_addr[31:0] = 32'h0000_1234;
    tick();
    check("single_mem_req", a_mem_req, 1);
    check("single_mem_addr", a_mem_addr, 32'h0000_1230);
    check("single_grant", a_grant, 0);
    check("single_busy", a_busy, 1);
    tick();
    tick();
    check("single_hold_req", a_mem_req, 1);
    a_mem_ready = 1'b1;
    a_mem_data  = line_a5;
    tick();
    check("single_ready", a_ready, 2'b01);
    check("single_data", a_data, line_a5);
    check("single_req_drop", a_mem_req, 0);
    a_mem_ready = 1'b0;
    a_valid     = 2'b00;
    tick();
    check("single_ready_pulse", a_ready, 0);
    check("single_idle_busy", a_busy, 0);
    check("single_data_hold", a_data, line_a5);

    // Simultaneous requests after reset
    rst = 1'b0;
    #1;
    rst = 1'b1;
    a_valid = 2'b11;
    a_addr  = {32'h0000_8008, 32'h0000_1234};
    tick();
    check("sim_grant0", a_grant, 0);
    a_mem_ready = 1'b1;
    a_mem_data  = line_d0;
    tick();
    check("sim_ready0", a_ready, 2'b01);
    a_mem_ready = 1'b0;
    a_valid     = 2'b10;
    tick();
    check("sim_gap_ready", a_ready, 0);
    check("sim_gap_req", a_mem_req, 0);
    tick();
    check("sim_grant1", a_grant, 1);
    check("sim_addr1", a_mem_addr, 32'h0000_8000);
    check("sim_req1", a_mem_req, 1);
    a_mem_ready = 1'b1;
    a_mem_data  = line_d1;
    tick();
    check("sim_ready1", a_ready, 2'b10);
    check("sim_data1", a_data, line_d1);
    a_mem_ready = 1'b0;

    // Fairness: both requesters hold valid; last grant was 1
    a_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_a_req();
      check("fair_req", a_mem_req, 1);
      check("fair_grant", a_grant, i % 2);
      a_mem_ready = 1'b1;
      tick();
      check("fair_ready", a_ready, 2'b01 << (i % 2));
      a_mem_ready = 1'b0;
    end
    a_valid = 2'b00;
    tick();
    tick();

    // Stray mem_ready in IDLE
    a_mem_ready = 1'b1;
    tick();
    tick();
    check("stray_ready", a_ready, 0);
    check("stray_req", a_mem_req, 0);
    check("stray_busy", a_busy, 0);
    a_mem_ready = 1'b0;

    // Four requesters: pointer decides, not index order
    b_valid = 4'b0010;
    b_addr[32 +: 32] = 32'h1111_2227;
    tick();
    check("b_grant1", b_grant, 1);
    check("b_addr1", b_mem_addr, 32'h1111_2220);
    b_mem_ready = 1'b1;
    tick();
    check("b_ready1", b_ready, 4'b0010);
    b_mem_ready = 1'b0;
    b_valid = 4'b1001;
    b_addr[96 +: 32] = 32'hABCD_EF1F;
    b_addr[0 +: 32]  = 32'h0000_0055;
    tick();
    tick();
    check("b_grant3", b_grant, 3);
    check("b_addr3", b_mem_addr, 32'hABCD_EF10);
    b_mem_ready = 1'b1;
    tick();
    check("b_ready3", b_ready, 4'b1000);
    b_mem_ready = 1'b0;
    b_valid = 4'b0000;
    tick();

    // Reset mid-refill: serve 0, start 1, reset during REQ
    a_valid = 2'b01;
    tick();
    check("mid_grant0", a_grant, 0);
    a_mem_ready = 1'b1;
    tick();
    a_mem_ready = 1'b0;
    a_valid = 2'b10;
    tick();
    tick();
    check("mid_grant1", a_grant, 1);
    check("mid_req1", a_mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_req", a_mem_req, 0);
    check("mid_async_busy", a_busy, 0);
    a_mem_ready = 1'b1;
    a_valid = 2'b00;
    #1;
    rst = 1'b1;
    tick();
    check("mid_no_ready_a", a_ready, 0);
    tick();
    check("mid_no_ready_b", a_ready, 0);
    check("mid_idle_req", a_mem_req, 0);
    a_mem_ready = 1'b0;
    a_valid = 2'b11;
    tick();
    check("mid_after_grant", a_grant, 0);
    a_mem_ready = 1'b1;
    tick();
    check("mid_after_ready", a_ready, 2'b01);
    a_mem_ready = 1'b0;

    // Withdrawal during REQ
    a_valid = 2'b10;
    a_addr[32 +: 32] = 32'h0000_9ABC;
    tick();
    tick();
    check("wd_grant", a_grant, 1);
    check("wd_addr", a_mem_addr, 32'h0000_9AB0);
    a_valid = 2'b00;
    a_addr[32 +: 32] = 32'hFFFF_FFFF;
    tick();
    check("wd_addr_hold", a_mem_addr, 32'h0000_9AB0);
    check("wd_req_hold", a_mem_req, 1);
    a_mem_ready = 1'b1;
    tick();
    check("wd_ready", a_ready, 2'b10);
    a_mem_ready = 1'b0;
    tick();
    check("wd_ready_once", a_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
